// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM state type and parity helper
// Purpose: common definitions for the UART transmitter and receiver.
// Ports: none (package).
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = 11;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Even parity: data plus this bit always carry an even number of ones.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time counter producing a pulse in the last cycle of each bit
// Purpose: counts 0..CLKS_PER_BIT-1 and wraps; bit_end marks the final cycle of a bit.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   clear   - hold the counter at zero (used while the line is idle)
//   bit_end - high in the last cycle of the current bit time
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // With one clock per bit the counter sits at zero and every cycle ends a bit.
  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1 UART transmitter with valid/ready byte input
// Purpose: serialises one byte per handshake as start, 8 data bits LSB first,
//          even parity and one stop bit, each held CLKS_PER_BIT cycles.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   in_data    - byte to send, latched at handshake
//   in_valid   - producer offers in_data
//   in_ready   - high only while idle; handshake = in_valid & in_ready
//   out_signal - registered serial line, idles high
//   busy       - frame in progress
//   frame_done - pulse in the final cycle of the stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_signal,
  output logic                      busy,
  output logic                      frame_done
);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic [2:0]                idx_q, idx_d;
  logic                      out_q, out_d;
  logic                      bit_end;
  logic                      baud_clear;

  // Holding the counter at zero while idle makes the start bit a full bit time.
  assign baud_clear = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_signal = out_q;

  // The line value for the next bit is chosen at the boundary so that
  // out_signal comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    idx_d      = idx_q;
    out_d      = out_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = UART_IDLE_LEVEL;
        if (in_valid) begin
          state_d  = START;
          shift_d  = in_data;
          parity_d = even_parity(in_data);
          idx_d    = 3'd0;
          out_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          out_d   = shift_q[0];
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            idx_d   = 3'd0;
            out_d   = parity_q;
          end else begin
            idx_d   = idx_q + 3'd1;
            out_d   = shift_q[0];
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          out_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d    = IDLE;
          out_d      = UART_IDLE_LEVEL;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      idx_q    <= 3'd0;
      out_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed bench for uart_transmitter at one and four clocks per bit
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [7:0] d1, d4;
  logic       v1, v4;
  logic       ready1, out1, busy1, fd1;
  logic       ready4, out4, busy4, fd4;

  int          checks = 0;
  int          errors = 0;
  int          n, fd_at, rdy;
  logic [63:0] s;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .reset(rst1), .in_data(d1), .in_valid(v1), .in_ready(ready1),
    .out_signal(out1), .busy(busy1), .frame_done(fd1)
  );

  uart_transmitter #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .reset(rst4), .in_data(d4), .in_valid(v4), .in_ready(ready4),
    .out_signal(out4), .busy(busy4), .frame_done(fd4)
  );

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  function automatic logic [63:0] stretch(input logic [10:0] f, input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 11 * k; i++) r[i] = f[i / k];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records the line once per cycle while busy; wiggle disturbs u4's inputs mid-frame.
  task automatic capture(input bit sel, input bit wiggle, output int cnt, output int fdi,
                         output int rdyc, output logic [63:0] st);
    cnt = 0; fdi = -1; rdyc = 0; st = '0;
    while ((sel ? busy4 : busy1) && cnt < 64) begin
      st[cnt] = sel ? out4 : out1;
      if (sel ? fd4 : fd1) fdi = cnt;
      if (sel ? ready4 : ready1) rdyc++;
      if (wiggle) begin
        d4 = ~d4;
        v4 = cnt[1];
      end
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; v1 = 1'b0; v4 = 1'b0; d1 = 8'h00; d4 = 8'h00;
    repeat (3) tick();
    rst1 = 1'b0; rst4 = 1'b0;
    check("rst_out1", out1, 1);
    check("rst_ready1", ready1, 1);
    check("rst_busy1", busy1, 0);
    check("rst_fd1", fd1, 0);
    check("rst_out4", out4, 1);
    check("rst_ready4", ready4, 1);

    // 8'hA5, one clock per bit
    d1 = 8'hA5; v1 = 1'b1; tick(); v1 = 1'b0;
    check("a5_start_next_cycle", out1, 0);
    capture(0, 0, n, fd_at, rdy, s);
    check("a5_bits", s, 64'(11'b10101001010));
    check("a5_len", n, 11);
    check("a5_fd_cycle", fd_at, 10);
    check("a5_ready_in_frame", rdy, 0);
    check("a5_idle_out", out1, 1);
    check("a5_idle_ready", ready1, 1);

    // 8'h07, four clocks per bit
    d4 = 8'h07; v4 = 1'b1; tick(); v4 = 1'b0;
    capture(1, 0, n, fd_at, rdy, s);
    check("h07_bits", s, stretch(11'b11000001110, 4));
    check("h07_parity", s[36], 1);
    check("h07_busy_cycles", n, 44);
    check("h07_fd_cycle", fd_at, 43);

    // back-to-back with in_valid held high
    d1 = 8'h00; v1 = 1'b1; tick(); d1 = 8'hFF;
    capture(0, 0, n, fd_at, rdy, s);
    check("b2b_h00_bits", s, 64'(11'b10000000000));
    check("b2b_h00_ready", rdy, 0);
    check("b2b_gap_out", out1, 1);
    check("b2b_gap_ready", ready1, 1);
    tick();
    check("b2b_second_busy", busy1, 1);
    capture(0, 0, n, fd_at, rdy, s);
    v1 = 1'b0;
    check("b2b_hff_bits", s, 64'(11'b10111111110));
    check("b2b_hff_len", n, 11);
    check("b2b_hff_ready", rdy, 0);
    tick();
    check("b2b_stopped", busy1, 0);

    // reset during the third data bit of 8'h3C
    d4 = 8'h3C; v4 = 1'b1; tick(); v4 = 1'b0;
    repeat (13) tick();
    check("abort_mid_busy", busy4, 1);
    check("abort_mid_bit2", out4, 1);
    tick(); tick();
    check("abort_mid_bit3", out4, 1);
    rst4 = 1'b1; tick();
    check("abort_out", out4, 1);
    check("abort_busy", busy4, 0);
    v4 = 1'b1; d4 = 8'h99; tick();
    check("rst_beats_handshake", busy4, 0);
    v4 = 1'b0; rst4 = 1'b0; tick();
    check("after_rst_busy", busy4, 0);
    check("after_rst_out", out4, 1);
    d4 = 8'h81; v4 = 1'b1; tick(); v4 = 1'b0;
    capture(1, 0, n, fd_at, rdy, s);
    check("h81_bits", s, stretch(11'b10100000010, 4));
    check("h81_len", n, 44);

    // in_data and in_valid disturbed during the frame
    d4 = 8'h5A; v4 = 1'b1; tick(); v4 = 1'b0;
    capture(1, 1, n, fd_at, rdy, s);
    v4 = 1'b0;
    check("h5a_bits", s, stretch(11'b10010110100, 4));
    check("h5a_len", n, 44);
    tick();
    check("h5a_no_extra_frame", busy4, 0);

    // every byte at one clock per bit
    for (int b = 0; b < 256; b++) begin
      d1 = 8'(b); v1 = 1'b1; tick(); v1 = 1'b0;
      capture(0, 0, n, fd_at, rdy, s);
      check($sformatf("sweep_%02h", b), s, 64'(frame_of(8'(b))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
